// File: rtl/bit_position_serializer_pkg.sv
// Shared types and width helpers for the set-bit serializer and its index consumers.
package bit_pos_pkg;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  function automatic int pos_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // One extra code point so an all-ones word can report a count of WIDTH.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/lowest_set_bit_finder.sv
// Combinational search for the lowest set bit of a word, plus a single-bit-set flag.
module lowest_set_bit_finder
  import bit_pos_pkg::*;
#(
  parameter  int WIDTH = 24,
  localparam int POS_W = pos_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic             found,
  output logic [POS_W-1:0] index,
  output logic [WIDTH-1:0] one_hot,
  output logic             is_single
);

  // Scanning downward lets the lowest set bit win the final assignment.
  always_comb begin
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        index = POS_W'(i);
      end
    end
  end

  assign found     = |vec;
  assign one_hot   = vec & (~vec + WIDTH'(1));
  assign is_single = found && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/bit_position_serializer.sv
// Expands an accepted word into one beat per set-bit index (lowest first), with last/empty flags and popcount.
module bit_position_serializer
  import bit_pos_pkg::*;
#(
  parameter  int WIDTH = 24,
  localparam int POS_W = pos_w(WIDTH),
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic             data_rdy_o,
  output logic [POS_W-1:0] pos_o,
  output logic             pos_val_o,
  input  logic             pos_rdy_i,
  output logic             pos_last_o,
  output logic             pos_empty_o,
  output logic [CNT_W-1:0] cnt_o
);

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] cur_one_hot;
  logic [WIDTH-1:0] shadow_next;
  logic [CNT_W-1:0] pop_cnt;
  logic             accept;
  logic             beat_hs;
  logic             nxt_found;
  logic [POS_W-1:0] nxt_index;
  logic [WIDTH-1:0] nxt_one_hot;
  logic             nxt_single;

  assign beat_hs    = pos_val_o && pos_rdy_i;
  assign data_rdy_o = (state == IDLE) || (pos_val_o && pos_last_o && pos_rdy_i);
  assign accept     = data_val_i && data_rdy_o;

  // The finder looks at the word as it will be after this edge, so outputs can stay registered.
  assign shadow_next = accept ? data_i : (shadow & ~cur_one_hot);

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_cnt = pop_cnt + CNT_W'(data_i[i]);
    end
  end

  lowest_set_bit_finder #(
    .WIDTH(WIDTH)
  ) u_finder (
    .vec      (shadow_next),
    .found    (nxt_found),
    .index    (nxt_index),
    .one_hot  (nxt_one_hot),
    .is_single(nxt_single)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state       <= IDLE;
      shadow      <= '0;
      cur_one_hot <= '0;
      pos_val_o   <= 1'b0;
      pos_o       <= '0;
      pos_last_o  <= 1'b0;
      pos_empty_o <= 1'b0;
      cnt_o       <= '0;
    end else if (accept) begin
      state       <= EMIT;
      shadow      <= shadow_next;
      cur_one_hot <= nxt_one_hot;
      pos_val_o   <= 1'b1;
      pos_o       <= nxt_index;
      pos_last_o  <= nxt_single || !nxt_found;
      pos_empty_o <= !nxt_found;
      cnt_o       <= pop_cnt;
    end else if (beat_hs) begin
      if (pos_last_o) begin
        state       <= IDLE;
        shadow      <= '0;
        cur_one_hot <= '0;
        pos_val_o   <= 1'b0;
        pos_o       <= '0;
        pos_last_o  <= 1'b0;
        pos_empty_o <= 1'b0;
        cnt_o       <= '0;
      end else begin
        shadow      <= shadow_next;
        cur_one_hot <= nxt_one_hot;
        pos_o       <= nxt_index;
        pos_last_o  <= nxt_single;
      end
    end
  end

endmodule

// File: tb/tb_bit_position_serializer.sv
// Randomized bench for bit_position_serializer checked against a queue-of-beats reference model.
module tb_bit_position_serializer;

  localparam int WIDTH = 24;

  typedef struct {
    int pos;
    bit last;
    bit empty;
    int cnt;
  } beat_t;

  logic              clk_i = 1'b0;
  logic              arst_n_i = 1'b0;
  logic [WIDTH-1:0]  data_i = '0;
  logic              data_val_i = 1'b0;
  logic              data_rdy_o;
  logic [4:0]        pos_o;
  logic              pos_val_o;
  logic              pos_rdy_i = 1'b0;
  logic              pos_last_o;
  logic              pos_empty_o;
  logic [4:0]        cnt_o;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    accepted;

  bit_position_serializer #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .data_i     (data_i),
    .data_val_i (data_val_i),
    .data_rdy_o (data_rdy_o),
    .pos_o      (pos_o),
    .pos_val_o  (pos_val_o),
    .pos_rdy_i  (pos_rdy_i),
    .pos_last_o (pos_last_o),
    .pos_empty_o(pos_empty_o),
    .cnt_o      (cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: the beats a word must produce, straight from the bit-index definition.
  function automatic void pushWord(input logic [WIDTH-1:0] d);
    beat_t b;
    int    total = 0;
    int    seen = 0;
    for (int i = 0; i < WIDTH; i++) total += int'(d[i]);
    if (total == 0) begin
      b = '{pos: 0, last: 1'b1, empty: 1'b1, cnt: 0};
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (d[i]) begin
          seen++;
          b = '{pos: i, last: (seen == total), empty: 1'b0, cnt: total};
          exp_q.push_back(b);
        end
      end
    end
  endfunction

  // One clock cycle: drive at the falling edge, check 1 time unit later, advance the model.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
    bit exp_rdy;
    data_val_i = v;
    data_i     = d;
    pos_rdy_i  = r;
    #1;
    exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && r);
    checkOutput("pos_val", int'(pos_val_o), int'(exp_q.size() != 0));
    checkOutput("data_rdy", int'(data_rdy_o), int'(exp_rdy));
    if (exp_q.size() != 0) begin
      checkOutput("pos", int'(pos_o), exp_q[0].pos);
      checkOutput("last", int'(pos_last_o), int'(exp_q[0].last));
      checkOutput("empty", int'(pos_empty_o), int'(exp_q[0].empty));
      checkOutput("cnt", int'(cnt_o), exp_q[0].cnt);
      if (r) void'(exp_q.pop_front());
    end
    accepted = v && exp_rdy;
    if (accepted) pushWord(d);
    @(negedge clk_i);
  endtask

  function automatic logic pickRdy(input int mode);
    return (mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
  endfunction

  task automatic sendWord(input logic [WIDTH-1:0] d, input int mode);
    int n = 0;
    accepted = 1'b0;
    while (!accepted && n < 200) begin
      applyStimulus(1'b1, d, pickRdy(mode));
      n++;
    end
    if (!accepted) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic drain(input int mode);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      applyStimulus(1'b0, WIDTH'($urandom), pickRdy(mode));
      n++;
    end
    checkOutput("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pos_val"}, int'(pos_val_o), 0);
    checkOutput({tag, "_data_rdy"}, int'(data_rdy_o), 1);
    checkOutput({tag, "_pos"}, int'(pos_o), 0);
    checkOutput({tag, "_last"}, int'(pos_last_o), 0);
    checkOutput({tag, "_empty"}, int'(pos_empty_o), 0);
    checkOutput({tag, "_cnt"}, int'(cnt_o), 0);
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    #2;
    checkResetValues("reset");
    @(negedge clk_i);
    arst_n_i = 1'b1;

    sendWord(24'h000005, 0);
    drain(0);
    sendWord(24'h000000, 0);
    drain(0);
    sendWord(24'hFFFFFF, 0);
    drain(0);
    sendWord(24'h810240, 1);
    drain(1);

    // Back-to-back words with the second accepted on the first word's last beat.
    applyStimulus(1'b1, 24'h800000, 1'b1);
    applyStimulus(1'b1, 24'h000001, 1'b1);
    checkOutput("b2b_accept", int'(accepted), 1);
    applyStimulus(1'b0, 24'h000000, 1'b1);
    checkOutput("b2b_drained", exp_q.size(), 0);

    // Reset in the middle of a burst must discard the rest of the word.
    sendWord(24'hFFFFFF, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 24'h000000, 1'b1);
    pos_rdy_i = 1'b0;
    arst_n_i  = 1'b0;
    #1;
    checkResetValues("midreset");
    exp_q.delete();
    @(negedge clk_i);
    arst_n_i = 1'b1;
    applyStimulus(1'b0, 24'h000000, 1'b1);
    sendWord(24'h000010, 0);
    drain(0);

    for (int w = 0; w < 60; w++) begin
      case ($urandom_range(0, 3))
        0:       d = WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom);
        1:       d = WIDTH'($urandom) | WIDTH'($urandom);
        2:       d = (w % 7 == 0) ? '0 : WIDTH'(1) << $urandom_range(0, WIDTH - 1);
        default: d = WIDTH'($urandom);
      endcase
      sendWord(d, $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) drain(1);
    end
    drain(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
